fpadd_norm_shift_pipe: RTL and testbench

- Pipelined normalisation stage for the floating-point adder datapath, placed after mantissa add/subtract and before rounding.
- Counts leading zeros of the (wF+2)-bit sum and left-shifts the sum by that full count, with no shift-range cap.
- Adjusts the exponent and flags zero and underflow.
- Elastic valid/ready pipeline, 2 register stages, full throughput.

---
 rtl/fpadd_norm_shift_pipe.sv | 144 ++++++++++++++
 tb/tb_fpadd_norm_shift_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fpadd_norm_shift_pipe.sv
// Purpose: FP adder normalisation stage: LZC of the mantissa sum, full left shift, exponent adjust, zero/underflow flags.
// Latency: 2 cycles from accept to out_valid, one result per cycle.
// Backpressure: elastic valid/ready; in_ready is combinational from out_ready only, stages hold while stalled.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake carrying fA (wF+2-bit sum) and eA (exponent)
//   out_valid/out_ready output handshake
//   fR, eR, lzc         normalised mantissa (shifted[wF+1:1]), adjusted exponent, applied shift count
//   zero, underflow     fA was zero; lzc exceeded eA (eR forced to 0)
//   sticky              shifted[0]; only built when FPADD_NORM_STICKY_EN is defined, else tied to 0
module fpadd_norm_shift_pipe #(
  parameter int wE = 4,
  parameter int wF = 5,
  localparam int wLZ = $clog2(wF + 3)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [wF+1:0]  fA,
  input  logic [wE-1:0]  eA,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [wF:0]    fR,
  output logic [wE-1:0]  eR,
  output logic [wLZ-1:0] lzc,
  output logic           zero,
  output logic           underflow,
  output logic           sticky
);

  // Stage A: captured operands plus their leading-zero count
  logic           vA_q;
  logic [wF+1:0]  fA_q;
  logic [wE-1:0]  eA_q;
  logic [wLZ-1:0] lzA_q, lzA_d;

  // Stage B: final results
  logic           vB_q;
  logic [wF:0]    fR_q, fR_d;
  logic [wE-1:0]  eR_q, eR_d;
  logic [wLZ-1:0] lzB_q;
  logic           zero_q, zero_d;
  logic           uf_q, uf_d;
  logic [wF+1:0]  shifted;

  logic advA, advB;

  // A stage may move when it is empty or the stage behind it moves.
  assign advB     = !vB_q || out_ready;
  assign advA     = !vA_q || advB;
  assign in_ready = advA;

  // Leading-zero count: higher set bits overwrite lower ones, so the MSB-most one wins.
  // An all-zero word keeps the default of wF+2.
  always_comb begin
    lzA_d = wLZ'(wF + 2);
    for (int i = 0; i < wF + 2; i++) begin
      if (fA[i]) lzA_d = wLZ'(wF + 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vA_q  <= 1'b0;
      fA_q  <= '0;
      eA_q  <= '0;
      lzA_q <= '0;
    end else if (advA) begin
      vA_q <= in_valid;
      if (in_valid) begin
        fA_q  <= fA;
        eA_q  <= eA;
        lzA_q <= lzA_d;
      end
    end
  end

  // Shift by the full count; a zero word shifts out to all zeros.
  assign shifted = fA_q << lzA_q;

  always_comb begin
    zero_d = (fA_q == '0);
    fR_d   = shifted[wF+1:1];
    uf_d   = 1'b0;
    eR_d   = '0;
    if (!zero_d) begin
      // Compare at 32 bits so lzc and eA widths need not match.
      if (int'(lzA_q) > int'(eA_q)) begin
        uf_d = 1'b1;
      end else begin
        // No underflow implies lzc <= eA, so truncating lzc to wE bits is lossless.
        eR_d = eA_q - wE'(lzA_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vB_q   <= 1'b0;
      fR_q   <= '0;
      eR_q   <= '0;
      lzB_q  <= '0;
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
    end else if (advB) begin
      vB_q <= vA_q;
      if (vA_q) begin
        fR_q   <= fR_d;
        eR_q   <= eR_d;
        lzB_q  <= lzA_q;
        zero_q <= zero_d;
        uf_q   <= uf_d;
      end
    end
  end

`ifdef FPADD_NORM_STICKY_EN
  // shifted[0] of a zero word is 0, so sticky is 0 whenever zero is set.
  logic sticky_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (advB && vA_q) begin
      sticky_q <= shifted[0];
    end
  end
  assign sticky = sticky_q;
`else
  // The dropped LSB has no consumer in this build.
  logic unused_shifted_lsb;
  assign unused_shifted_lsb = shifted[0];
  assign sticky = 1'b0;
`endif

  assign out_valid = vB_q;
  assign fR        = fR_q;
  assign eR        = eR_q;
  assign lzc       = lzB_q;
  assign zero      = zero_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_fpadd_norm_shift_pipe.sv
// Purpose: directed self-checking bench for fpadd_norm_shift_pipe (wE=4, wF=5).
// Latency: checks the 2-cycle accept-to-result timing on every single-word vector.
// Backpressure: streams five words through a 4-cycle output stall and a mid-stream reset.
module tb_fpadd_norm_shift_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] fA;
  logic [3:0] eA;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] fR;
  logic [3:0] eR;
  logic [2:0] lzc;
  logic       zero;
  logic       underflow;
  logic       sticky;

  // Result bundle compared as one word: {fR, eR, lzc, zero, underflow, sticky}
  logic [15:0] res;
  assign res = {fR, eR, lzc, zero, underflow, sticky};

`ifdef FPADD_NORM_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  fpadd_norm_shift_pipe #(.wE(4), .wF(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fA        (fA),
    .eA        (eA),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fR        (fR),
    .eR        (eR),
    .lzc       (lzc),
    .zero      (zero),
    .underflow (underflow),
    .sticky    (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ex(input logic [5:0] fr, input logic [3:0] er,
                                     input logic [2:0] lz, input logic z,
                                     input logic u, input logic s);
    return {fr, er, lz, z, u, s};
  endfunction

  // One word through an idle pipe with out_ready high: no result after one
  // cycle, result present exactly two cycles after the accepting edge.
  task automatic run_vec(input string tag, input logic [6:0] f, input logic [3:0] e,
                         input logic [15:0] exp);
    @(posedge clk); #1;
    fA = f; eA = e; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(res), 32'(exp));
  endtask

  logic [6:0]  sf [5];
  logic [3:0]  se [5];
  logic [15:0] sx [5];

  initial begin
    int tx;
    int rx;
    logic held_v;
    logic [15:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fA = '0; eA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst = 1'b0;

    run_vec("basic",   7'b0010110, 4'd6, ex(6'b101100, 4'd4, 3'd2, 1'b0, 1'b0, 1'b0));
    run_vec("zero",    7'b0000000, 4'd9, ex(6'b000000, 4'd0, 3'd7, 1'b1, 1'b0, 1'b0));
    run_vec("uflow",   7'b0000001, 4'd3, ex(6'b100000, 4'd0, 3'd6, 1'b0, 1'b1, 1'b0));
    run_vec("sticky",  7'b1000011, 4'd5, ex(6'b100001, 4'd5, 3'd0, 1'b0, 1'b0, STK));
    run_vec("lz_eq_e", 7'b0001000, 4'd3, ex(6'b100000, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0));

    // Backpressure stream: out_ready low on cycles 3..6.
    sf[0] = 7'b1010101; se[0] = 4'd8;  sx[0] = ex(6'b101010, 4'd8,  3'd0, 1'b0, 1'b0, STK);
    sf[1] = 7'b0110011; se[1] = 4'd2;  sx[1] = ex(6'b110011, 4'd1,  3'd1, 1'b0, 1'b0, 1'b0);
    sf[2] = 7'b0001101; se[2] = 4'd15; sx[2] = ex(6'b110100, 4'd12, 3'd3, 1'b0, 1'b0, 1'b0);
    sf[3] = 7'b0000111; se[3] = 4'd4;  sx[3] = ex(6'b111000, 4'd0,  3'd4, 1'b0, 1'b0, 1'b0);
    sf[4] = 7'b0000011; se[4] = 4'd2;  sx[4] = ex(6'b110000, 4'd0,  3'd5, 1'b0, 1'b1, 1'b0);
    tx = 0; rx = 0; held_v = 1'b0; held = '0;
    @(posedge clk); // let the last single-vector result drain
    for (int c = 0; c < 40 && rx < 5; c++) begin
      @(posedge clk); #1;
      if (held_v) begin
        chk("stall_vld", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'(res), 32'(held));
      end
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (tx < 5);
      if (tx < 5) begin
        fA = sf[tx]; eA = se[tx];
      end
      #1;
      if (c >= 3 && c <= 6) chk("bp_rdy", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        chk("bp_word", 32'(res), 32'(sx[rx]));
        rx++;
      end
      held_v = out_valid && !out_ready;
      held   = res;
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    chk("bp_rx_count", 32'(rx), 32'd5);
    chk("bp_tx_count", 32'(tx), 32'd5);
    @(posedge clk); #2;
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset while two words are in flight and held by backpressure.
    @(posedge clk); #1;
    fA = 7'b0100000; eA = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    fA = 7'b0010000; eA = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk("mrst_stale", 32'(out_valid), 32'd0);
    end
    run_vec("post_rst", 7'b0011111, 4'd7, ex(6'b111110, 4'd5, 3'd2, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
